// File: rtl/return_stack.sv
// Call/return stack for the decode stage: circular storage, separate occupancy
// count, sticky overflow/underflow flags and a selectable full-stack policy.
module return_stack #(
  parameter  int WORD_LENGTH = 12,
  parameter  int DEPTH       = 8,
  parameter  int WRAP_MODE   = 0,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   stall,
  input  logic [WORD_LENGTH-1:0] in,
  output logic [WORD_LENGTH-1:0] result,
  output logic [CW-1:0]          count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clear_err
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  logic [WORD_LENGTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]          r_tp;
  logic [CW-1:0]          r_count;
  logic                   r_overflow;
  logic                   r_underflow;

  logic [PW-1:0]          w_tp_inc;
  logic [PW-1:0]          w_tp_dec;
  logic [PW-1:0]          w_wr_idx;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_do_push;
  logic                   w_do_pop;
  logic                   w_do_replace;
  logic                   w_wrap_push;
  logic                   w_ovf_evt;
  logic                   w_unf_evt;
  logic                   w_wr_en;

  // push and pop are single-cycle request strobes with no handshake: each one
  // is acted on at the edge it is sampled high unless stall or rst masks it.

  // Explicit wrap compares keep the pointer legal for non-power-of-2 DEPTH.
  always_comb begin
    w_tp_inc = (r_tp == LAST_IDX) ? '0 : r_tp + PW'(1);
    w_tp_dec = (r_tp == '0) ? LAST_IDX : r_tp - PW'(1);
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  assign w_push = push & ~stall;
  assign w_pop  = pop  & ~stall;

  // Push+pop on a non-empty stack rewrites the top; on an empty one it is a push.
  assign w_do_replace = w_push & w_pop & ~w_empty;
  assign w_do_push    = w_push & (~w_pop | w_empty) & ~w_full;
  assign w_wrap_push  = w_push & ~w_pop & w_full & (WRAP_MODE != 0);
  assign w_do_pop     = w_pop & ~w_push & ~w_empty;

  assign w_ovf_evt = w_push & ~w_pop & w_full;
  assign w_unf_evt = w_pop & ~w_push & w_empty;

  assign w_wr_en  = ~rst & (w_do_push | w_wrap_push | w_do_replace);
  assign w_wr_idx = w_do_replace ? w_tp_dec : r_tp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_tp    <= w_tp_inc;
        r_count <= r_count + CW'(1);
      end else if (w_wrap_push) begin
        r_tp    <= w_tp_inc;
      end else if (w_do_pop) begin
        r_tp    <= w_tp_dec;
        r_count <= r_count - CW'(1);
      end
      // A new error event wins over a same-cycle clear.
      r_overflow  <= w_ovf_evt | (r_overflow  & ~clear_err);
      r_underflow <= w_unf_evt | (r_underflow & ~clear_err);
    end
  end

  // Storage is never reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= in;
    end
  end

  assign result    = w_empty ? '0 : r_mem[w_tp_dec];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
